// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and
// datapath control field codes.
package control_pkg;

    localparam logic [3:0] OP_TYPEA = 4'b1111;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b0000;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        MULDIV,
        WB,
        HALT
    } state_t;

    localparam logic [2:0] JB_NONE = 3'b000;
    localparam logic [2:0] JB_BLT  = 3'b001;
    localparam logic [2:0] JB_BGT  = 3'b010;
    localparam logic [2:0] JB_BEQ  = 3'b011;
    localparam logic [2:0] JB_JMP  = 3'b100;

    localparam logic [1:0] ALU_TYPEA = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_ADDR  = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] RW_NONE   = 2'b00;
    localparam logic [1:0] RW_SINGLE = 2'b01;
    localparam logic [1:0] RW_PAIR   = 2'b11;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/multiDiv decode into static datapath fields and
// instruction class flags; the sequencer decides when each field is visible.
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] multiDiv,
    output logic       aluBType,
    output logic       aluSrc,
    output logic       zeroExtendFlag,
    output logic       memToReg,
    output logic       storeByte,
    output logic [1:0] aluControlOp,
    output logic [2:0] jumpBranch,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_muldiv,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        aluBType       = 1'b0;
        aluSrc         = 1'b0;
        zeroExtendFlag = 1'b0;
        memToReg       = 1'b0;
        storeByte      = 1'b0;
        aluControlOp   = ALU_TYPEA;
        jumpBranch     = JB_NONE;
        is_load        = 1'b0;
        is_store       = 1'b0;
        is_branch      = 1'b0;
        is_muldiv      = 1'b0;
        is_halt        = 1'b0;
        is_illegal     = 1'b0;
        case (opcode)
            OP_TYPEA: is_muldiv = (multiDiv != 2'b00);
            OP_ANDI: begin
                aluSrc       = 1'b1;
                aluControlOp = ALU_AND;
            end
            OP_ORI: begin
                aluSrc       = 1'b1;
                aluControlOp = ALU_OR;
            end
            OP_LBU, OP_LW: begin
                aluBType       = 1'b1;
                aluControlOp   = ALU_ADDR;
                zeroExtendFlag = (opcode == OP_LBU);
                memToReg       = 1'b1;
                is_load        = 1'b1;
            end
            OP_SB, OP_SW: begin
                aluBType     = 1'b1;
                aluControlOp = ALU_ADDR;
                storeByte    = (opcode == OP_SB);
                is_store     = 1'b1;
            end
            OP_BLT: begin
                jumpBranch = JB_BLT;
                is_branch  = 1'b1;
            end
            OP_BGT: begin
                jumpBranch = JB_BGT;
                is_branch  = 1'b1;
            end
            OP_BEQ: begin
                jumpBranch = JB_BEQ;
                is_branch  = 1'b1;
            end
            OP_JMP: begin
                jumpBranch = JB_JMP;
                is_branch  = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: FETCH/EXEC/MEM/MULDIV/WB/HALT with per-state
// qualification of the decoded datapath controls.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned MULDIV_LAT    = 4,
    parameter bit          ILLEGAL_HALTS = 1'b0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [3:0] opcode,
    input  logic [1:0] multiDiv,
    input  logic       mem_ready,
    output logic       instr_ready,
    output logic       aluBType,
    output logic       aluSrc,
    output logic       zeroExtendFlag,
    output logic       memRead,
    output logic       memToReg,
    output logic       memWrite,
    output logic       storeByte,
    output logic [1:0] aluControlOp,
    output logic [1:0] regWrite,
    output logic [2:0] jumpBranch,
    output logic       halted,
    output logic       illegal_op,
    output logic       busy
);

    state_t             state, state_nx;
    logic [3:0]         op_q;
    logic [1:0]         md_q;
    logic [CNT_W-1:0]   cnt;

    logic       d_bt, d_src, d_zx, d_m2r, d_sb;
    logic [1:0] d_aop;
    logic [2:0] d_jb;
    logic       d_load, d_store, d_branch, d_muldiv, d_halt, d_ill;

    control_decode u_decode (
        .opcode         (op_q),
        .multiDiv       (md_q),
        .aluBType       (d_bt),
        .aluSrc         (d_src),
        .zeroExtendFlag (d_zx),
        .memToReg       (d_m2r),
        .storeByte      (d_sb),
        .aluControlOp   (d_aop),
        .jumpBranch     (d_jb),
        .is_load        (d_load),
        .is_store       (d_store),
        .is_branch      (d_branch),
        .is_muldiv      (d_muldiv),
        .is_halt        (d_halt),
        .is_illegal     (d_ill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            op_q  <= '0;
            md_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && instr_valid) begin
                op_q <= opcode;
                md_q <= multiDiv;
            end
            // Loaded on entry so the final MULDIV cycle is the one that reads zero.
            if (state == EXEC && d_muldiv && !d_ill) begin
                cnt <= CNT_W'(MULDIV_LAT - 1);
            end else if (state == MULDIV && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  if (instr_valid) state_nx = EXEC;
            EXEC: begin
                if (d_ill)                   state_nx = ILLEGAL_HALTS ? HALT : FETCH;
                else if (d_halt)             state_nx = HALT;
                else if (d_branch)           state_nx = FETCH;
                else if (d_load || d_store)  state_nx = MEM;
                else if (d_muldiv)           state_nx = MULDIV;
                else                         state_nx = WB;
            end
            MEM:    if (mem_ready) state_nx = d_load ? WB : FETCH;
            MULDIV: if (cnt == '0) state_nx = WB;
            WB:     state_nx = FETCH;
            HALT:   state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    // Outputs are forced low while rst is asserted, whatever the prior state.
    always_comb begin
        instr_ready    = 1'b0;
        aluBType       = 1'b0;
        aluSrc         = 1'b0;
        zeroExtendFlag = 1'b0;
        memRead        = 1'b0;
        memToReg       = 1'b0;
        memWrite       = 1'b0;
        storeByte      = 1'b0;
        aluControlOp   = '0;
        regWrite       = RW_NONE;
        jumpBranch     = JB_NONE;
        halted         = 1'b0;
        illegal_op     = 1'b0;
        busy           = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: instr_ready = 1'b1;
                EXEC: begin
                    aluBType       = d_bt;
                    aluSrc         = d_src;
                    aluControlOp   = d_aop;
                    zeroExtendFlag = d_zx;
                    jumpBranch     = d_jb;
                    illegal_op     = d_ill;
                    busy           = 1'b1;
                end
                MEM: begin
                    aluBType       = d_bt;
                    aluSrc         = d_src;
                    aluControlOp   = d_aop;
                    zeroExtendFlag = d_zx;
                    memRead        = d_load;
                    memWrite       = d_store;
                    storeByte      = d_sb;
                    busy           = 1'b1;
                end
                MULDIV: begin
                    aluBType     = d_bt;
                    aluSrc       = d_src;
                    aluControlOp = d_aop;
                    busy         = 1'b1;
                end
                WB: begin
                    regWrite       = d_muldiv ? RW_PAIR : RW_SINGLE;
                    memToReg       = d_m2r;
                    zeroExtendFlag = d_zx;
                    busy           = 1'b1;
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: two instances (MULDIV_LAT=4/ILLEGAL_HALTS=0 and
// MULDIV_LAT=1/ILLEGAL_HALTS=1) share stimulus; each cycle both are compared.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [1:0] multiDiv;
    logic       mem_ready;

    logic       ir_a, bt_a, src_a, zx_a, mr_a, m2r_a, mw_a, sb_a, h_a, il_a, bz_a;
    logic [1:0] aop_a, rw_a;
    logic [2:0] jb_a;
    logic       ir_b, bt_b, src_b, zx_b, mr_b, m2r_b, mw_b, sb_b, h_b, il_b, bz_b;
    logic [1:0] aop_b, rw_b;
    logic [2:0] jb_b;

    logic [17:0] out_a, out_b;
    assign out_a = {ir_a, bt_a, src_a, zx_a, mr_a, m2r_a, mw_a, sb_a, aop_a, rw_a, jb_a, h_a, il_a, bz_a};
    assign out_b = {ir_b, bt_b, src_b, zx_b, mr_b, m2r_b, mw_b, sb_b, aop_b, rw_b, jb_b, h_b, il_b, bz_b};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MULDIV_LAT(4), .ILLEGAL_HALTS(1'b0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .multiDiv(multiDiv), .mem_ready(mem_ready), .instr_ready(ir_a),
        .aluBType(bt_a), .aluSrc(src_a), .zeroExtendFlag(zx_a), .memRead(mr_a),
        .memToReg(m2r_a), .memWrite(mw_a), .storeByte(sb_a), .aluControlOp(aop_a),
        .regWrite(rw_a), .jumpBranch(jb_a), .halted(h_a), .illegal_op(il_a), .busy(bz_a)
    );

    multicycle_control #(.MULDIV_LAT(1), .ILLEGAL_HALTS(1'b1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .multiDiv(multiDiv), .mem_ready(mem_ready), .instr_ready(ir_b),
        .aluBType(bt_b), .aluSrc(src_b), .zeroExtendFlag(zx_b), .memRead(mr_b),
        .memToReg(m2r_b), .memWrite(mw_b), .storeByte(sb_b), .aluControlOp(aop_b),
        .regWrite(rw_b), .jumpBranch(jb_b), .halted(h_b), .illegal_op(il_b), .busy(bz_b)
    );

    function automatic logic [17:0] ctl(input logic ir, bt, src, zx, mr, m2r, mw, sb,
                                        input logic [1:0] aop, rw, input logic [2:0] jb,
                                        input logic h, il, bz);
        return {ir, bt, src, zx, mr, m2r, mw, sb, aop, rw, jb, h, il, bz};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [17:0] ea, input logic [17:0] eb);
        @(posedge clk);
        #1;
        check({tag, "/a"}, {14'b0, out_a}, {14'b0, ea});
        check({tag, "/b"}, {14'b0, out_b}, {14'b0, eb});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [17:0] Z, F, BUSY, H, WB1, WB2, ORI_EX, ANDI_EX, LBU_EX, LBU_MEM, LBU_WB;
        logic [17:0] LS_EX, LW_MEM, LW_WB, SB_MEM, BEQ_EX, ILL_EX;
        //          ir bt sr zx mr m2 mw sb aop    rw     jb      h  il bz
        Z       = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        F       = ctl(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        BUSY    = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 1);
        H       = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0);
        WB1     = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0, 0, 1);
        WB2     = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 3'b000, 0, 0, 1);
        ORI_EX  = ctl(0, 0, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0, 0, 1);
        ANDI_EX = ctl(0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0, 1);
        LBU_EX  = ctl(0, 1, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 0, 0, 1);
        LBU_MEM = ctl(0, 1, 0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 3'b000, 0, 0, 1);
        LBU_WB  = ctl(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b01, 3'b000, 0, 0, 1);
        LS_EX   = ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 0, 0, 1);
        LW_MEM  = ctl(0, 1, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b000, 0, 0, 1);
        LW_WB   = ctl(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b000, 0, 0, 1);
        SB_MEM  = ctl(0, 1, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 3'b000, 0, 0, 1);
        BEQ_EX  = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b011, 0, 0, 1);
        ILL_EX  = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1, 1);

        rst = 1'b1; instr_valid = 1'b0; opcode = 4'b0000; multiDiv = 2'b00; mem_ready = 1'b0;
        step("reset", Z, Z);
        rst = 1'b0; instr_valid = 1'b1; opcode = 4'b0010;
        #1;
        check("fetch_after_reset/a", {14'b0, out_a}, {14'b0, F});
        check("fetch_after_reset/b", {14'b0, out_b}, {14'b0, F});

        step("ori_exec", ORI_EX, ORI_EX);
        instr_valid = 1'b0;
        step("ori_wb", WB1, WB1);
        step("ori_fetch", F, F);

        instr_valid = 1'b1; opcode = 4'b0001;
        step("andi_exec", ANDI_EX, ANDI_EX);
        instr_valid = 1'b0;
        step("andi_wb", WB1, WB1);
        step("andi_fetch", F, F);

        instr_valid = 1'b1; opcode = 4'b1010; mem_ready = 1'b0;
        step("lbu_exec", LBU_EX, LBU_EX);
        instr_valid = 1'b0;
        step("lbu_mem1", LBU_MEM, LBU_MEM);
        step("lbu_mem2", LBU_MEM, LBU_MEM);
        step("lbu_mem3", LBU_MEM, LBU_MEM);
        step("lbu_mem4", LBU_MEM, LBU_MEM);
        mem_ready = 1'b1;
        step("lbu_wb", LBU_WB, LBU_WB);
        step("lbu_fetch", F, F);

        instr_valid = 1'b1; opcode = 4'b1100;
        step("lw_exec", LS_EX, LS_EX);
        instr_valid = 1'b0;
        step("lw_mem", LW_MEM, LW_MEM);
        step("lw_wb", LW_WB, LW_WB);
        step("lw_fetch", F, F);

        instr_valid = 1'b1; opcode = 4'b1011;
        step("sb_exec", LS_EX, LS_EX);
        instr_valid = 1'b0;
        step("sb_mem", SB_MEM, SB_MEM);
        step("sb_fetch", F, F);

        mem_ready = 1'b0; instr_valid = 1'b1; opcode = 4'b1111; multiDiv = 2'b10;
        step("md_exec", BUSY, BUSY);
        instr_valid = 1'b0;
        step("md_cyc1", BUSY, BUSY);
        step("md_cyc2", BUSY, WB2);
        step("md_cyc3", BUSY, F);
        step("md_cyc4", BUSY, F);
        step("md_wb", WB2, F);
        step("md_fetch", F, F);

        instr_valid = 1'b1; opcode = 4'b0110; multiDiv = 2'b00;
        step("beq_exec", BEQ_EX, BEQ_EX);
        instr_valid = 1'b0;
        step("beq_after", F, F);

        instr_valid = 1'b1; opcode = 4'b1000;
        step("illegal_exec", ILL_EX, ILL_EX);
        instr_valid = 1'b0;
        step("illegal_next", F, H);

        instr_valid = 1'b1; opcode = 4'b0000;
        step("halt_exec", BUSY, H);
        instr_valid = 1'b0;
        step("halt_state", H, H);
        opcode = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            instr_valid = ~instr_valid;
            step("halt_hold", H, H);
        end

        instr_valid = 1'b0; rst = 1'b1;
        step("rst_from_halt", Z, Z);
        rst = 1'b0; instr_valid = 1'b1; opcode = 4'b1111; multiDiv = 2'b01;
        step("md2_exec", BUSY, BUSY);
        instr_valid = 1'b0;
        step("md2_cyc1", BUSY, BUSY);
        rst = 1'b1;
        step("rst_mid_muldiv", Z, Z);
        rst = 1'b0;
        #1;
        check("fetch_after_md_rst/a", {14'b0, out_a}, {14'b0, F});
        check("fetch_after_md_rst/b", {14'b0, out_b}, {14'b0, F});

        instr_valid = 1'b1; opcode = 4'b1100; multiDiv = 2'b00; mem_ready = 1'b0;
        step("lw2_exec", LS_EX, LS_EX);
        instr_valid = 1'b0;
        step("lw2_mem1", LW_MEM, LW_MEM);
        step("lw2_mem2", LW_MEM, LW_MEM);
        rst = 1'b1;
        step("rst_mid_mem", Z, Z);
        rst = 1'b0;
        #1;
        check("fetch_after_mem_rst/a", {14'b0, out_a}, {14'b0, F});
        check("fetch_after_mem_rst/b", {14'b0, out_b}, {14'b0, F});
        step("fetch_stays", F, F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
